// File: rtl/pid_tuner_pkg.sv
// pid_tuner_pkg
// Shared types for the PID gain tuner:
//   rpt_state_t   - auto-repeat FSM state (IDLE, HOLD, REPEAT)
//   step_sel_t    - which step is applied this cycle (NONE when no step)
//   step_priority - resolves several step buttons to one winner
package pid_tuner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        INC_S = 3'd1,
        INC_L = 3'd2,
        DEC_S = 3'd3,
        DEC_L = 3'd4
    } step_sel_t;

    // Bit order of the step-button vector used throughout the design.
    localparam int BTN_INC_S = 0;
    localparam int BTN_INC_L = 1;
    localparam int BTN_DEC_S = 2;
    localparam int BTN_DEC_L = 3;
    localparam int BTN_SEL   = 4;

    // inc_small > inc_large > dec_small > dec_large.
    function automatic step_sel_t step_priority(input logic [3:0] b);
        step_sel_t r;
        if (b[BTN_INC_S])      r = INC_S;
        else if (b[BTN_INC_L]) r = INC_L;
        else if (b[BTN_DEC_S]) r = DEC_S;
        else if (b[BTN_DEC_L]) r = DEC_L;
        else                   r = NONE;
        return r;
    endfunction

endpackage

// File: rtl/saturating_adder_signed_unsigned.sv
// saturating_adder_signed_unsigned
// Adds a signed offset to an unsigned value and clamps the result to
// [0, 2^A_WIDTH-1].
//   a   in  A_WIDTH  unsigned operand
//   b   in  B_WIDTH  signed offset
//   y   out A_WIDTH  clamped sum
//   sat out 1        high when the true sum lay outside the range
module saturating_adder_signed_unsigned #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 32
) (
    input  logic [A_WIDTH-1:0]        a,
    input  logic signed [B_WIDTH-1:0] b,
    output logic [A_WIDTH-1:0]        y,
    output logic                      sat
);

    // Two guard bits: one for the sign, one for the carry.
    localparam int S_W = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 2;
    localparam logic signed [S_W-1:0] MAX_VAL =
        $signed({{(S_W-A_WIDTH){1'b0}}, {A_WIDTH{1'b1}}});

    logic signed [S_W-1:0] a_ext;
    logic signed [S_W-1:0] b_ext;
    logic signed [S_W-1:0] sum;

    always_comb begin
        a_ext = $signed({{(S_W-A_WIDTH){1'b0}}, a});
        b_ext = $signed({{(S_W-B_WIDTH){b[B_WIDTH-1]}}, b});
        sum   = a_ext + b_ext;
        if (sum < 0) begin
            y   = '0;
            sat = 1'b1;
        end else if (sum > MAX_VAL) begin
            y   = '1;
            sat = 1'b1;
        end else begin
            y   = sum[A_WIDTH-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/pid_gain_tuner.sv
// pid_gain_tuner
// Button-driven editor for a bank of unsigned PID gains with press
// detection, priority resolution, hold-to-repeat and saturation.
//   clk            in   system clock
//   reset          in   asynchronous active-low reset
//   btn_inc_small, btn_inc_large, btn_dec_small, btn_dec_large
//                  in   debounced step buttons (high = pressed)
//   btn_sel        in   debounced select button, advances sel
//   load_default   in   level, forces DEFAULT_GAINS
//   lock           in   level, freezes all editing
//   gains          out  packed gains, gain i at [i*GAIN_WIDTH +: GAIN_WIDTH]
//   sel            out  selected gain index
//   gain_updated   out  pulse with the first cycle of a changed gain value
//   sat            out  pulse when a step was clipped
//   fsm_state      out  repeat FSM state (rpt_state_t encoding)
//
// Handshake: none; every input is a level sampled on each rising clk edge
// and every output is registered and valid for the whole following cycle.
module pid_gain_tuner
    import pid_tuner_pkg::*;
#(
    parameter int N_GAINS       = 3,
    parameter int GAIN_WIDTH    = 16,
    parameter int SMALL_STEP    = 10,
    parameter int LARGE_STEP    = 100,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter logic [N_GAINS*GAIN_WIDTH-1:0] DEFAULT_GAINS = '0,
    localparam int SEL_W = (N_GAINS > 1) ? $clog2(N_GAINS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          btn_inc_small,
    input  logic                          btn_inc_large,
    input  logic                          btn_dec_small,
    input  logic                          btn_dec_large,
    input  logic                          btn_sel,
    input  logic                          load_default,
    input  logic                          lock,
    output logic [N_GAINS*GAIN_WIDTH-1:0] gains,
    output logic [SEL_W-1:0]              sel,
    output logic                          gain_updated,
    output logic                          sat,
    output logic [1:0]                    fsm_state
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N_GAINS - 1);
    localparam logic signed [31:0] D_SMALL = 32'(SMALL_STEP);
    localparam logic signed [31:0] D_LARGE = 32'(LARGE_STEP);

    // ---------------------------------------------------------------
    // Button capture and press detection
    // ---------------------------------------------------------------
    logic [4:0] btn;
    logic [4:0] btn_q;
    logic [4:0] armed;
    logic [4:0] press;
    logic [4:0] held;
    logic       blocked;

    assign btn     = {btn_sel, btn_dec_large, btn_dec_small, btn_inc_large, btn_inc_small};
    assign blocked = lock | load_default;

    // A button is armed once it has been seen released while editing is
    // allowed. Buttons held across reset, lock or load_default stay
    // disarmed until released, so they never produce a spurious press.
    assign press = btn & ~btn_q & armed;
    assign held  = btn & armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= '0;
            armed <= '0;
        end else begin
            btn_q <= btn;
            armed <= ~btn | (armed & {5{~blocked}});
        end
    end

    step_sel_t press_win;
    step_sel_t held_win;
    logic      sel_press;

    assign press_win = step_priority(press[3:0]);
    assign held_win  = step_priority(held[3:0]);
    assign sel_press = press[BTN_SEL] & ~blocked;

    // ---------------------------------------------------------------
    // Selection
    // ---------------------------------------------------------------
    logic [SEL_W-1:0] sel_next;
    logic             sel_change;

    always_comb begin
        sel_next = sel;
        if (sel_press) begin
            sel_next = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
        end
    end

    assign sel_change = (sel_next != sel);

    // ---------------------------------------------------------------
    // Repeat FSM: state register / next state / outputs
    // ---------------------------------------------------------------
    rpt_state_t       state;
    rpt_state_t       state_next;
    step_sel_t        win_q;
    step_sel_t        win_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             count_done;
    step_sel_t        step_kind;

    assign count_done = ((state == HOLD)   && (cnt == DELAY_LAST)) ||
                        ((state == REPEAT) && (cnt == PERIOD_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            win_q <= NONE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            win_q <= win_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        win_next   = win_q;
        cnt_next   = cnt;
        if (blocked) begin
            state_next = IDLE;
            win_next   = NONE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_win != NONE) begin
                        state_next = HOLD;
                        win_next   = press_win;
                        cnt_next   = '0;
                    end
                end
                HOLD, REPEAT: begin
                    if (held_win == NONE) begin
                        state_next = IDLE;
                        win_next   = NONE;
                        cnt_next   = '0;
                    end else if (held_win != win_q) begin
                        // New winner (release or takeover): restart as a fresh press.
                        state_next = HOLD;
                        win_next   = held_win;
                        cnt_next   = '0;
                    end else if (count_done) begin
                        state_next = REPEAT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    win_next   = NONE;
                    cnt_next   = '0;
                end
            endcase
            if (sel_change) begin
                state_next = IDLE;
                win_next   = NONE;
                cnt_next   = '0;
            end
        end
    end

    always_comb begin
        step_kind = NONE;
        if (!blocked) begin
            case (state)
                IDLE: step_kind = press_win;
                HOLD, REPEAT: begin
                    if (held_win != NONE && held_win != win_q) begin
                        step_kind = held_win;
                    end else if (held_win != NONE && count_done) begin
                        step_kind = win_q;
                    end
                end
                default: step_kind = NONE;
            endcase
        end
    end

    assign fsm_state = state;

    // ---------------------------------------------------------------
    // Datapath: one adder on the selected gain
    // ---------------------------------------------------------------
    logic [GAIN_WIDTH-1:0]         cur_gain;
    logic [GAIN_WIDTH-1:0]         new_gain;
    logic signed [31:0]            delta;
    logic                          add_sat;
    logic [N_GAINS*GAIN_WIDTH-1:0] gains_next;
    logic                          sat_next;
    logic                          upd_next;

    assign cur_gain = gains[sel*GAIN_WIDTH +: GAIN_WIDTH];

    always_comb begin
        case (step_kind)
            INC_S:   delta = D_SMALL;
            INC_L:   delta = D_LARGE;
            DEC_S:   delta = -D_SMALL;
            DEC_L:   delta = -D_LARGE;
            default: delta = '0;
        endcase
    end

    saturating_adder_signed_unsigned #(
        .A_WIDTH(GAIN_WIDTH),
        .B_WIDTH(32)
    ) u_adder (
        .a   (cur_gain),
        .b   (delta),
        .y   (new_gain),
        .sat (add_sat)
    );

    always_comb begin
        gains_next = gains;
        if (load_default) begin
            gains_next = DEFAULT_GAINS;
        end else if (step_kind != NONE) begin
            gains_next[sel*GAIN_WIDTH +: GAIN_WIDTH] = new_gain;
        end
    end

    // step_kind is NONE whenever load_default is high, so sat is a step-only event.
    assign sat_next = (step_kind != NONE) & add_sat;
    assign upd_next = (gains_next != gains);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gains        <= DEFAULT_GAINS;
            sel          <= '0;
            gain_updated <= 1'b0;
            sat          <= 1'b0;
        end else begin
            gains        <= gains_next;
            sel          <= sel_next;
            gain_updated <= upd_next;
            sat          <= sat_next;
        end
    end

endmodule

// File: tb/tb_pid_gain_tuner.sv
// tb_pid_gain_tuner
// Directed scenarios followed by random button activity, all checked every
// cycle against a cycle-level behavioural model of the tuner.
module tb_pid_gain_tuner;
    import pid_tuner_pkg::*;

    localparam int NG = 3;
    localparam int GW = 16;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int GMAX = 65535;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_inc_small = 1'b0, btn_inc_large = 1'b0;
    logic btn_dec_small = 1'b0, btn_dec_large = 1'b0;
    logic btn_sel = 1'b0, load_default = 1'b0, lock = 1'b0;
    logic [NG*GW-1:0] gains;
    logic [1:0] sel;
    logic gain_updated, sat;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    pid_gain_tuner #(
        .N_GAINS(NG), .GAIN_WIDTH(GW), .SMALL_STEP(10), .LARGE_STEP(100),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .DEFAULT_GAINS({16'd0, 16'd0, 16'd100})
    ) dut (
        .clk(clk), .reset(reset),
        .btn_inc_small(btn_inc_small), .btn_inc_large(btn_inc_large),
        .btn_dec_small(btn_dec_small), .btn_dec_large(btn_dec_large),
        .btn_sel(btn_sel), .load_default(load_default), .lock(lock),
        .gains(gains), .sel(sel), .gain_updated(gain_updated), .sat(sat),
        .fsm_state(fsm_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: gains as integers, the current hold described by
    // its owning button, cycles since its last step and steps taken so far.
    // ------------------------------------------------------------------
    int m_g[NG];
    int m_sel;
    bit m_prev[5];
    bit m_armed[5];
    int owner;
    int since;
    int nsteps;
    int def_g[NG] = '{100, 0, 0};
    int step_val[4] = '{10, 100, -10, -100};

    task automatic push_expect(input bit upd, input bit clip);
        logic [1:0] st;
        for (int i = 0; i < NG; i++) exp_q.push_back(32'(m_g[i]));
        exp_q.push_back(32'(m_sel));
        exp_q.push_back({31'd0, upd});
        exp_q.push_back({31'd0, clip});
        if (owner < 0)        st = IDLE;
        else if (nsteps == 1) st = HOLD;
        else                  st = REPEAT;
        exp_q.push_back({30'd0, st});
    endtask

    task automatic model_step();
        bit lv[5];
        bit pr[5];
        bit hd[5];
        bit blocked;
        bit clip;
        bit upd;
        int old[NG];
        int kind;
        int p;
        int v;
        lv[0] = btn_inc_small; lv[1] = btn_inc_large;
        lv[2] = btn_dec_small; lv[3] = btn_dec_large; lv[4] = btn_sel;
        clip = 0;
        kind = -1;
        if (!reset) begin
            m_g = def_g;
            m_sel = 0;
            owner = -1;
            since = 0;
            nsteps = 0;
            for (int i = 0; i < 5; i++) begin
                m_prev[i] = 0;
                m_armed[i] = 0;
            end
            push_expect(0, 0);
            return;
        end
        old = m_g;
        blocked = lock || load_default;
        for (int i = 0; i < 5; i++) begin
            pr[i] = lv[i] && !m_prev[i] && m_armed[i];
            hd[i] = lv[i] && m_armed[i];
        end
        if (load_default) begin
            m_g = def_g;
            owner = -1;
        end else if (lock) begin
            owner = -1;
        end else begin
            if (owner < 0) begin
                p = -1;
                for (int i = 3; i >= 0; i--) if (pr[i]) p = i;
                if (p >= 0) begin
                    kind = p; owner = p; since = 0; nsteps = 1;
                end
            end else begin
                p = -1;
                for (int i = 3; i >= 0; i--) if (hd[i]) p = i;
                if (p < 0) begin
                    owner = -1;
                end else if (p != owner) begin
                    kind = p; owner = p; since = 0; nsteps = 1;
                end else begin
                    since++;
                    if (since == ((nsteps == 1) ? RD : RP)) begin
                        kind = owner; since = 0; nsteps++;
                    end
                end
            end
            if (kind >= 0) begin
                v = m_g[m_sel] + step_val[kind];
                if (v < 0) begin v = 0; clip = 1; end
                if (v > GMAX) begin v = GMAX; clip = 1; end
                m_g[m_sel] = v;
            end
            if (pr[4]) begin
                p = (m_sel + 1) % NG;
                if (p != m_sel) owner = -1;
                m_sel = p;
            end
        end
        for (int i = 0; i < 5; i++) begin
            m_armed[i] = !lv[i] || (m_armed[i] && !blocked);
            m_prev[i] = lv[i];
        end
        upd = 0;
        for (int i = 0; i < NG; i++) if (m_g[i] != old[i]) upd = 1;
        push_expect(upd, clip);
    endtask

    // One clock: model predicts, DUT clocks, outputs compared #1 after edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NG; i++) check("gain", {16'd0, gains[i*GW +: GW]}, exp_q.pop_front());
        check("sel", {30'd0, sel}, exp_q.pop_front());
        check("gain_updated", {31'd0, gain_updated}, exp_q.pop_front());
        check("sat", {31'd0, sat}, exp_q.pop_front());
        check("fsm_state", {30'd0, fsm_state}, exp_q.pop_front());
    endtask

    task automatic set_btn(input int idx, input logic val);
        case (idx)
            0: btn_inc_small = val;
            1: btn_inc_large = val;
            2: btn_dec_small = val;
            3: btn_dec_large = val;
            default: btn_sel = val;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        tick();
        set_btn(idx, 1'b0);
        tick();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        ticks(2);
        check("reset_gain0", {16'd0, gains[15:0]}, 32'd100);
        check("reset_sel", {30'd0, sel}, 32'd0);
        #2 reset = 1'b1;
        ticks(2);

        // Scenario 1: single small increment.
        btn_inc_small = 1'b1;
        tick();
        check("s1_gain0", {16'd0, gains[15:0]}, 32'd110);
        check("s1_upd", {31'd0, gain_updated}, 32'd1);
        check("s1_sat", {31'd0, sat}, 32'd0);
        btn_inc_small = 1'b0;
        tick();

        // Scenario 2: hold dec_large from 250 down into saturation.
        press(1);
        for (int i = 0; i < 4; i++) press(0);
        check("s2_start", {16'd0, gains[15:0]}, 32'd250);
        btn_dec_large = 1'b1;
        tick();
        check("s2_press", {16'd0, gains[15:0]}, 32'd150);
        ticks(RD);
        check("s2_first_repeat", {16'd0, gains[15:0]}, 32'd50);
        ticks(RP);
        check("s2_clip_gain", {16'd0, gains[15:0]}, 32'd0);
        check("s2_clip_sat", {31'd0, sat}, 32'd1);
        ticks(RP);
        check("s2_sat_only", {31'd0, sat}, 32'd1);
        check("s2_no_upd", {31'd0, gain_updated}, 32'd0);
        btn_dec_large = 1'b0;
        tick();

        // Scenario 3: simultaneous press, then priority handover.
        press(1);
        press(1);
        btn_inc_small = 1'b1;
        btn_dec_large = 1'b1;
        tick();
        check("s3_priority", {16'd0, gains[15:0]}, 32'd210);
        btn_inc_small = 1'b0;
        tick();
        check("s3_handover", {16'd0, gains[15:0]}, 32'd110);
        btn_dec_large = 1'b0;
        tick();

        // Scenario 4: select wrap and same-cycle select + step.
        press(4);
        check("s4_sel1", {30'd0, sel}, 32'd1);
        press(4);
        check("s4_sel2", {30'd0, sel}, 32'd2);
        press(4);
        check("s4_sel0", {30'd0, sel}, 32'd0);
        press(4);
        btn_sel = 1'b1;
        btn_inc_large = 1'b1;
        tick();
        check("s4_gain1", {16'd0, gains[31:16]}, 32'd100);
        check("s4_sel_after", {30'd0, sel}, 32'd2);
        btn_sel = 1'b0;
        btn_inc_large = 1'b0;
        tick();

        // Scenario 5: lock freezes edits; held button needs a re-press.
        lock = 1'b1;
        btn_inc_small = 1'b1;
        tick();
        check("s5_locked", {16'd0, gains[47:32]}, 32'd0);
        check("s5_no_upd", {31'd0, gain_updated}, 32'd0);
        tick();
        lock = 1'b0;
        ticks(3);
        check("s5_held_after_lock", {16'd0, gains[47:32]}, 32'd0);
        btn_inc_small = 1'b0;
        tick();
        press(0);
        check("s5_repress", {16'd0, gains[47:32]}, 32'd10);

        // Scenario 6: reset mid-repeat, then load_default after an edit.
        btn_inc_small = 1'b1;
        ticks(1 + RD + RP + 2);
        check("s6_repeating", {30'd0, fsm_state}, {30'd0, REPEAT});
        reset = 1'b0;
        tick();
        check("s6_rst_gain0", {16'd0, gains[15:0]}, 32'd100);
        check("s6_rst_gain2", {16'd0, gains[47:32]}, 32'd0);
        check("s6_rst_sel", {30'd0, sel}, 32'd0);
        check("s6_rst_upd", {31'd0, gain_updated}, 32'd0);
        tick();
        reset = 1'b1;
        ticks(3);
        check("s6_held_after_reset", {16'd0, gains[15:0]}, 32'd100);
        btn_inc_small = 1'b0;
        tick();
        press(0);
        load_default = 1'b1;
        tick();
        check("s6_load_gain0", {16'd0, gains[15:0]}, 32'd100);
        check("s6_load_upd", {31'd0, gain_updated}, 32'd1);
        tick();
        check("s6_load_once", {31'd0, gain_updated}, 32'd0);
        load_default = 1'b0;
        tick();

        // Random activity with long holds so repeats and takeovers occur.
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) begin
                    case (b)
                        0: btn_inc_small = ~btn_inc_small;
                        1: btn_inc_large = ~btn_inc_large;
                        2: btn_dec_small = ~btn_dec_small;
                        default: btn_dec_large = ~btn_dec_large;
                    endcase
                end
            if ($urandom_range(0, 5) == 0) btn_sel = ~btn_sel;
            if ($urandom_range(0, 39) == 0) lock = ~lock;
            if (load_default) load_default = ($urandom_range(0, 1) == 0);
            else load_default = ($urandom_range(0, 79) == 0);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
